// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - command codes, parser state type and length decode for the UART command frame parser
package uart_cmd_pkg;

  // Host command codes (ASCII letters).
  localparam logic [7:0] parSETIMG = 8'h53;  // 'S' select boot image
  localparam logic [7:0] parCRCIMG = 8'h43;  // 'C' compute image CRC
  localparam logic [7:0] parRDDATA = 8'h52;  // 'R' read flash data
  localparam logic [7:0] parERASE  = 8'h45;  // 'E' erase sector
  localparam logic [7:0] parGETST  = 8'h47;  // 'G' get status
  localparam logic [7:0] parSETADR = 8'h41;  // 'A' set address
  localparam logic [7:0] parVERIFY = 8'h56;  // 'V' verify image
  localparam logic [7:0] parWRDATA = 8'h4B;  // 'K' write flash data

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    HOLD = 3'd4
  } state_t;

  // A LEN byte of zero stands for a full 256-byte payload.
  function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
    return (len_byte == 8'h00) ? 9'd256 : {1'b0, len_byte};
  endfunction

  function automatic logic is_cmd(input logic [7:0] code);
    case (code)
      parSETIMG, parCRCIMG, parRDDATA, parERASE,
      parGETST, parSETADR, parVERIFY, parWRDATA: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/frame_payload_ram.sv
// rtl/frame_payload_ram.sv - simple dual-port payload buffer with registered read
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write byte
//   raddr  in   read address
//   rdata  out  read byte, one cycle after raddr
module frame_payload_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 8'h00;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/uart_cmd_frame_parser.sv
// rtl/uart_cmd_frame_parser.sv - assembles and checks CMD,LEN,payload,CSUM host frames from the UART byte stream
// Ports:
//   inclk      in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx_data    in   received byte
//   rx_valid   in   rx_data strobe
//   rx_err     in   framing/parity error strobe for the current byte
//   frm_valid  out  checked frame held for the executor
//   frm_ack    in   executor consumed the frame
//   frm_cmd    out  command code of the held frame
//   frm_len    out  payload length 1..256
//   buf_raddr  in   payload read address
//   buf_rdata  out  payload byte, 1-cycle latency
//   err_csum   out  pulse: checksum mismatch
//   err_tout   out  pulse: inter-byte timeout or rx_err inside a frame
//   err_cmd    out  pulse: unknown command or length too large
//   err_ovr    out  pulse: byte dropped while holding a frame
//   busy       out  parser not idle
module uart_cmd_frame_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLOCK      = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int NUMBER     = 256,
  parameter int RX_TIMEOUT = 2
) (
  input  logic       inclk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic       frm_valid,
  input  logic       frm_ack,
  output logic [7:0] frm_cmd,
  output logic [8:0] frm_len,
  input  logic [7:0] buf_raddr,
  output logic [7:0] buf_rdata,
  output logic       err_csum,
  output logic       err_tout,
  output logic       err_cmd,
  output logic       err_ovr,
  output logic       busy
);

  // Idle limit: RX_TIMEOUT character times of 10 bits each.
  localparam int             TOUT_LIMIT = RX_TIMEOUT * 10 * (CLOCK / BAUD);
  localparam int             TW         = $clog2(TOUT_LIMIT + 1);
  localparam logic [TW-1:0]  TOUT_MAX   = TW'(TOUT_LIMIT);
  localparam int             AW         = $clog2(NUMBER);
  localparam logic [9:0]     NUM_MAX    = 10'(NUMBER);

  state_t        state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [8:0]    len_q, len_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          frm_valid_q;
  logic          err_csum_q, err_tout_q, err_cmd_q, err_ovr_q;

  logic          e_csum, e_tout, e_cmd, e_ovr;
  logic          in_frame;
  logic          ram_we;
  logic [8:0]    dec_len;
  logic [7:0]    sum_plus;

  assign in_frame = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign dec_len  = frame_len(rx_data);
  assign sum_plus = sum_q + rx_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    sum_d   = sum_q;
    e_csum  = 1'b0;
    e_tout  = 1'b0;
    e_cmd   = 1'b0;
    e_ovr   = 1'b0;
    ram_we  = 1'b0;

    // Counter saturates at the limit; an arriving byte always clears it,
    // so a byte coinciding with expiry is accepted.
    if (!in_frame || rx_valid) begin
      tout_d = '0;
    end else if (tout_q != TOUT_MAX) begin
      tout_d = tout_q + 1'b1;
    end else begin
      tout_d = tout_q;
    end

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (is_cmd(rx_data)) begin
            cmd_d   = rx_data;
            sum_d   = rx_data;
            cnt_d   = '0;
            state_d = LEN;
          end else begin
            e_cmd = 1'b1;
          end
        end
      end
      LEN, DATA, CSUM: begin
        if (rx_err) begin
          e_tout  = 1'b1;
          state_d = IDLE;
        end else if (rx_valid) begin
          if (state_q == LEN) begin
            len_d = dec_len;
            if ({1'b0, dec_len} > NUM_MAX) begin
              e_cmd   = 1'b1;
              state_d = IDLE;
            end else begin
              sum_d   = sum_plus;
              cnt_d   = '0;
              state_d = DATA;
            end
          end else if (state_q == DATA) begin
            ram_we = 1'b1;
            sum_d  = sum_plus;
            if (cnt_q == len_q - 9'd1) begin
              state_d = CSUM;
            end else begin
              cnt_d = cnt_q + 9'd1;
            end
          end else begin
            if (sum_plus == 8'hFF) begin
              state_d = HOLD;
            end else begin
              e_csum  = 1'b1;
              state_d = IDLE;
            end
          end
        end else if (tout_q == TOUT_MAX) begin
          e_tout  = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        // Bytes are dropped here even when the ack lands on the same cycle.
        if (rx_valid) begin
          e_ovr = 1'b1;
        end
        if (frm_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      cmd_q       <= '0;
      sum_q       <= '0;
      tout_q      <= '0;
      frm_valid_q <= 1'b0;
      err_csum_q  <= 1'b0;
      err_tout_q  <= 1'b0;
      err_cmd_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      sum_q       <= sum_d;
      tout_q      <= tout_d;
      frm_valid_q <= (state_d == HOLD);
      err_csum_q  <= e_csum;
      err_tout_q  <= e_tout;
      err_cmd_q   <= e_cmd;
      err_ovr_q   <= e_ovr;
    end
  end

  frame_payload_ram #(
    .DEPTH (NUMBER),
    .AW    (AW)
  ) u_ram (
    .clk   (inclk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (cnt_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (buf_raddr[AW-1:0]),
    .rdata (buf_rdata)
  );

  assign frm_valid = frm_valid_q;
  assign frm_cmd   = cmd_q;
  assign frm_len   = len_q;
  assign err_csum  = err_csum_q;
  assign err_tout  = err_tout_q;
  assign err_cmd   = err_cmd_q;
  assign err_ovr   = err_ovr_q;
  assign busy      = (state_q != IDLE);

endmodule
